// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  // Architectural zero register; writes to it never create a hazard.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Hazard controller FSM states; encoding value 3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hctrl_state_t;

endpackage : riscv_pipe_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX destination.
module load_use_detect #(
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  memtoreg_ex,
  input  logic                  reg_en_ex,
  output logic                  load_use
);
  import riscv_pipe_pkg::*;

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  // A load into a real register whose result an ID-stage source is about to read.
  always_comb begin
    rd_live  = memtoreg_ex & reg_en_ex & (rd_ex != REG_ADDR_W'(REG_X0));
    rs1_hit  = rs1_used_id & (rs1_id == rd_ex);
    rs2_hit  = rs2_used_id & (rs2_id == rd_ex);
    load_use = rd_live & (rs1_hit | rs2_hit);
  end

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / flush sequencing for the IF/ID and ID/EX pipeline registers,
// with saturating stall and taken-branch event counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = riscv_pipe_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  memtoreg_ex,
  input  logic                  reg_en_ex,
  input  logic                  pcsrc_ex,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import riscv_pipe_pkg::*;

  // The flush counter only needs to hold FLUSH_CYCLES-1.
  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hctrl_state_t    state;
  hctrl_state_t    state_nxt;
  logic [FC_W-1:0] fcnt;
  logic [FC_W-1:0] fcnt_nxt;
  logic            load_use;
  logic            stall_evt;
  logic            flush_evt;
  logic            stall_take;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .rd_ex       (rd_ex),
    .memtoreg_ex (memtoreg_ex),
    .reg_en_ex   (reg_en_ex),
    .load_use    (load_use)
  );

  // Load-use is only honoured from RUN; LOAD_STALL already inserted its bubble.
  assign stall_take = load_use & (state == RUN);

  // Next-state, flush-counter and event decode with mem_busy > pcsrc_ex > load_use.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (mem_busy) begin
      stall_evt = 1'b1;
    end else begin
      case (state)
        RUN, LOAD_STALL: begin
          if (pcsrc_ex) begin
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FC_LOAD;
            end else begin
              state_nxt = RUN;
            end
          end else if (stall_take) begin
            stall_evt = 1'b1;
            state_nxt = LOAD_STALL;
          end else begin
            state_nxt = RUN;
          end
        end
        FLUSH: begin
          fcnt_nxt = fcnt - FC_W'(1);
          if (fcnt == FC_W'(1)) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FLUSH;
          end
        end
        default: begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Enable/flush decode of the current state and inputs; reset forces a safe idle pipe.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    if (!reset_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
    end else begin
      case (state)
        RUN, LOAD_STALL: begin
          if (pcsrc_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (stall_take) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else begin
            pc_en      = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          pc_en      = 1'b1;
        end
      endcase
    end
  end

  assign state_o = state;

  // FSM state and flush counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_evt && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_evt && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised bench for pipeline_hazard_ctrl: two instances (default parameters and
// FLUSH_CYCLES=1 / CNT_W=4) driven in lockstep against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       rs1_used_id, rs2_used_id, memtoreg_ex, reg_en_ex, pcsrc_ex, mem_busy;

  logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush;
  logic [1:0]  a_state;
  logic [15:0] a_stall_count, a_flush_count;
  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
  logic [1:0]  b_state;
  logic [3:0]  b_stall_count, b_flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: remaining flush cycles, "just stalled" flag, counts.
  int rem  [2];
  bit stl  [2];
  int sc   [2];
  int fcn  [2];
  int fcyc [2] = '{2, 1};
  int cmax [2] = '{65535, 15};

  always #5 clock = ~clock;

  pipeline_hazard_ctrl u_a (
    .clock(clock), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .memtoreg_ex(memtoreg_ex), .reg_en_ex(reg_en_ex), .pcsrc_ex(pcsrc_ex), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .idex_en(a_idex_en),
    .idex_flush(a_idex_flush), .state_o(a_state), .stall_count(a_stall_count),
    .flush_count(a_flush_count)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_b (
    .clock(clock), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .memtoreg_ex(memtoreg_ex), .reg_en_ex(reg_en_ex), .pcsrc_ex(pcsrc_ex), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .idex_en(b_idex_en),
    .idex_flush(b_idex_flush), .state_o(b_state), .stall_count(b_stall_count),
    .flush_count(b_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return memtoreg_ex && reg_en_ex && (rd_ex != 5'd0) &&
           ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; stl[i] = 1'b0; sc[i] = 0; fcn[i] = 0;
    end
  endtask

  // Expected {pc_en, ifid_en, ifid_flush, idex_en, idex_flush} and state for instance i.
  task automatic model_out(input int i, output logic [4:0] o, output logic [1:0] st);
    if (!reset_n)                 o = 5'b00101;
    else if (mem_busy)            o = 5'b00000;
    else if (rem[i] > 0)          o = 5'b11111;
    else if (pcsrc_ex)            o = 5'b11111;
    else if (model_lu() && !stl[i]) o = 5'b00011;
    else                          o = 5'b11010;
    st = (rem[i] > 0) ? 2'd2 : (stl[i] ? 2'd1 : 2'd0);
  endtask

  task automatic model_step(input int i);
    if (!reset_n) begin
      rem[i] = 0; stl[i] = 1'b0; sc[i] = 0; fcn[i] = 0;
    end else if (mem_busy) begin
      if (sc[i] < cmax[i]) sc[i]++;
    end else if (rem[i] > 0) begin
      rem[i]--;
    end else if (pcsrc_ex) begin
      if (fcn[i] < cmax[i]) fcn[i]++;
      rem[i] = fcyc[i] - 1;
      stl[i] = 1'b0;
    end else if (model_lu() && !stl[i]) begin
      if (sc[i] < cmax[i]) sc[i]++;
      stl[i] = 1'b1;
    end else begin
      stl[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [4:0] o;
    logic [1:0] st;
    model_out(0, o, st);
    chk("a_outs",  {27'd0, a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush}, {27'd0, o});
    chk("a_state", {30'd0, a_state}, {30'd0, st});
    chk("a_stall_count", {16'd0, a_stall_count}, sc[0]);
    chk("a_flush_count", {16'd0, a_flush_count}, fcn[0]);
    model_out(1, o, st);
    chk("b_outs",  {27'd0, b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush}, {27'd0, o});
    chk("b_state", {30'd0, b_state}, {30'd0, st});
    chk("b_stall_count", {28'd0, b_stall_count}, sc[1]);
    chk("b_flush_count", {28'd0, b_flush_count}, fcn[1]);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic run_cycle(input bit do_chk);
    #1;
    if (do_chk) check_all();
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
  endtask

  task automatic set_idle();
    rs1_id = 5'd1; rs2_id = 5'd2; rd_ex = 5'd3;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; memtoreg_ex = 1'b0; reg_en_ex = 1'b0;
    pcsrc_ex = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lw_x5();
    memtoreg_ex = 1'b1; reg_en_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    reset_model();
    run_cycle(1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    int s0;
    reset_n = 1'b0;
    set_idle();
    reset_model();
    @(negedge clock);
    run_cycle(1'b1);
    reset_n = 1'b1;

    // 1: load-use stall, then one LOAD_STALL cycle with defaults even though hazard persists
    set_lw_x5();
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("t1_stall_count", {16'd0, a_stall_count}, 32'd1);
    set_idle();
    run_cycle(1'b1);

    // 2: no hazard when rd_ex=0 or the source is not used
    set_lw_x5(); rd_ex = 5'd0; rs1_id = 5'd0;
    run_cycle(1'b1);
    set_lw_x5(); rs1_used_id = 1'b0;
    run_cycle(1'b1);
    chk("t2_stall_count", {16'd0, a_stall_count}, 32'd1);
    set_idle();

    // 3: taken branch -> two flush cycles then RUN
    do_reset();
    pcsrc_ex = 1'b1;
    run_cycle(1'b1);
    pcsrc_ex = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("t3_flush_count", {16'd0, a_flush_count}, 32'd1);
    chk("t3_state", {30'd0, a_state}, 32'd0);

    // 4: branch beats load-use in the same cycle
    s0 = sc[0];
    set_lw_x5(); pcsrc_ex = 1'b1;
    run_cycle(1'b1);
    set_idle();
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("t4_stall_unchanged", {16'd0, a_stall_count}, s0);

    // 5: memory freeze during the last flush cycle
    s0 = sc[0];
    pcsrc_ex = 1'b1;
    run_cycle(1'b1);
    pcsrc_ex = 1'b0; mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle(1'b1);
    mem_busy = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("t5_stall_plus3", {16'd0, a_stall_count}, s0 + 3);

    // 6: asynchronous reset between edges in the middle of FLUSH
    pcsrc_ex = 1'b1;
    run_cycle(1'b1);
    pcsrc_ex = 1'b0;
    #2;
    reset_n = 1'b0;
    reset_model();
    #1;
    chk("t6_state_async", {30'd0, a_state}, 32'd0);
    chk("t6_flush_count_async", {16'd0, a_flush_count}, 32'd0);
    chk("t6_ifid_flush_async", {31'd0, a_ifid_flush}, 32'd1);
    @(negedge clock);
    run_cycle(1'b1);
    reset_n = 1'b1;
    run_cycle(1'b1);

    // Saturation of the 16-bit stall counter under a long freeze
    mem_busy = 1'b1;
    for (int k = 0; k < 65540; k++) run_cycle(1'b0);
    run_cycle(1'b1);
    chk("sat_stall_ffff", {16'd0, a_stall_count}, 32'h0000_FFFF);
    mem_busy = 1'b0;
    run_cycle(1'b1);

    // Randomised traffic with narrow register indices so hazards are frequent
    for (int k = 0; k < 1500; k++) begin
      rs1_id      = 5'($urandom_range(0, 3));
      rs2_id      = 5'($urandom_range(0, 3));
      rd_ex       = 5'($urandom_range(0, 3));
      rs1_used_id = 1'($urandom_range(0, 1));
      rs2_used_id = 1'($urandom_range(0, 1));
      memtoreg_ex = ($urandom_range(0, 99) < 60);
      reg_en_ex   = ($urandom_range(0, 99) < 80);
      pcsrc_ex    = ($urandom_range(0, 99) < 15);
      mem_busy    = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        reset_model();
      end else begin
        reset_n = 1'b1;
      end
      run_cycle(1'b1);
    end
    reset_n = 1'b1;
    set_idle();
    run_cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
